// File: rtl/pll_lock_sequencer_pkg.sv
// Shared state encoding, loop-filter profile type and default profile table for the
// PLL lock sequencer.
package pll_lock_sequencer_pkg;

    typedef enum logic [2:0] {
        StRst,
        StWaitLock,
        StStable,
        StLocked,
        StLost,
        StFail
    } state_t;

    typedef struct packed {
        logic [5:0] icpsel;
        logic [2:0] lpfres;
        logic [1:0] lpfcap;
    } profile_t;

    localparam int unsigned PROFILE_COUNT = 4;
    localparam int unsigned PROFILE_IDX_W = $clog2(PROFILE_COUNT);

    // Listed highest index first; entry 0 is the power-up profile.
    localparam profile_t [PROFILE_COUNT-1:0] PROFILE_TABLE = {
        {6'h2e, 3'd6, 2'd3},
        {6'h1c, 3'd5, 2'd2},
        {6'h12, 3'd4, 2'd1},
        {6'h0a, 3'd3, 2'd0}
    };

    // Out-of-range selects fall back to profile 0.
    function automatic profile_t profile_lookup(input int unsigned sel,
                                                input int unsigned num_profiles);
        if (sel < num_profiles && sel < PROFILE_COUNT) begin
            return PROFILE_TABLE[PROFILE_IDX_W'(sel)];
        end
        return PROFILE_TABLE[0];
    endfunction

endpackage

// File: rtl/pll_lock_sync.sv
// Two-flop synchronizer for a single asynchronous level; clears to 0 on synchronous reset.
module pll_lock_sync (
    input  logic clk_i,
    input  logic reset_i,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/pll_lock_sequencer.sv
// PLL reset/lock sequencer with loop-filter profile selection, timeout/retry and lock
// qualification. Define PLLSEQ_AUTO_RELOCK_EN to restart automatically after lock loss.
module pll_lock_sequencer
    import pll_lock_sequencer_pkg::*;
#(
    parameter int unsigned RESET_CYCLES       = 64,
    parameter int unsigned LOCK_TIMEOUT       = 500000,
    parameter int unsigned LOCK_STABLE_CYCLES = 1024,
    parameter int unsigned MAX_RETRIES        = 3,
    parameter int unsigned NUM_PROFILES       = 4
) (
    input  logic                               clkin,
    input  logic                               reset,
    input  logic                               apply,
    input  logic [$clog2(NUM_PROFILES)-1:0]    profile_sel,
    input  logic                               pll_lock,
    output logic                               pll_reset,
    output logic [5:0]                         icpsel,
    output logic [2:0]                         lpfres,
    output logic [1:0]                         lpfcap,
    output logic                               busy,
    output logic                               locked,
    output logic                               fail,
    output logic                               lock_lost,
    output logic [$clog2(MAX_RETRIES+1)-1:0]   retry_cnt
);

    localparam int unsigned RST_W   = $clog2(RESET_CYCLES + 1);
    localparam int unsigned TMO_W   = $clog2(LOCK_TIMEOUT + 1);
    localparam int unsigned STB_W   = $clog2(LOCK_STABLE_CYCLES + 1);
    localparam int unsigned RETRY_W = $clog2(MAX_RETRIES + 1);

    logic               lock_s;
    state_t             state_q;
    logic [RST_W-1:0]   rst_cnt_q;
    logic [TMO_W-1:0]   tmo_cnt_q;
    logic [STB_W-1:0]   stb_cnt_q;
    logic [RETRY_W-1:0] retry_q;
    profile_t           prof_q;
    logic               pll_reset_q;
    logic               busy_q;
    logic               locked_q;
    logic               fail_q;
    logic               lock_lost_q;

    logic rst_done;
    logic timed_out;
    logic stable_done;

    pll_lock_sync u_lock_sync (
        .clk_i   (clkin),
        .reset_i (reset),
        .d_i     (pll_lock),
        .q_o     (lock_s)
    );

    assign rst_done    = (rst_cnt_q == RST_W'(RESET_CYCLES - 1));
    assign timed_out   = (tmo_cnt_q == TMO_W'(LOCK_TIMEOUT - 1));
    assign stable_done = (stb_cnt_q == STB_W'(LOCK_STABLE_CYCLES - 1));

    always_ff @(posedge clkin) begin
        lock_lost_q <= 1'b0;
        if (reset) begin
            state_q     <= StRst;
            rst_cnt_q   <= '0;
            tmo_cnt_q   <= '0;
            stb_cnt_q   <= '0;
            retry_q     <= '0;
            prof_q      <= PROFILE_TABLE[0];
            pll_reset_q <= 1'b1;
            busy_q      <= 1'b1;
            locked_q    <= 1'b0;
            fail_q      <= 1'b0;
        end else if (apply) begin
            state_q     <= StRst;
            rst_cnt_q   <= '0;
            retry_q     <= '0;
            prof_q      <= profile_lookup(32'(profile_sel), NUM_PROFILES);
            pll_reset_q <= 1'b1;
            busy_q      <= 1'b1;
            locked_q    <= 1'b0;
            fail_q      <= 1'b0;
        end else begin
            case (state_q)
                StRst: begin
                    if (rst_done) begin
                        state_q     <= StWaitLock;
                        pll_reset_q <= 1'b0;
                        tmo_cnt_q   <= '0;
                    end else begin
                        rst_cnt_q <= rst_cnt_q + RST_W'(1);
                    end
                end
                // The timeout spans both states; a stable count finishing wins over timeout.
                StWaitLock, StStable: begin
                    if (state_q == StStable && lock_s && stable_done) begin
                        state_q  <= StLocked;
                        locked_q <= 1'b1;
                        busy_q   <= 1'b0;
                    end else if (timed_out) begin
                        if (retry_q < RETRY_W'(MAX_RETRIES)) begin
                            state_q     <= StRst;
                            rst_cnt_q   <= '0;
                            retry_q     <= retry_q + RETRY_W'(1);
                            pll_reset_q <= 1'b1;
                        end else begin
                            state_q <= StFail;
                            fail_q  <= 1'b1;
                            busy_q  <= 1'b0;
                        end
                    end else begin
                        tmo_cnt_q <= tmo_cnt_q + TMO_W'(1);
                        if (state_q == StWaitLock) begin
                            if (lock_s) begin
                                state_q   <= StStable;
                                stb_cnt_q <= '0;
                            end
                        end else if (lock_s) begin
                            stb_cnt_q <= stb_cnt_q + STB_W'(1);
                        end else begin
                            state_q   <= StWaitLock;
                            stb_cnt_q <= '0;
                        end
                    end
                end
                StLocked: begin
                    if (!lock_s) begin
                        lock_lost_q <= 1'b1;
                        locked_q    <= 1'b0;
`ifdef PLLSEQ_AUTO_RELOCK_EN
                        state_q     <= StRst;
                        rst_cnt_q   <= '0;
                        retry_q     <= '0;
                        pll_reset_q <= 1'b1;
                        busy_q      <= 1'b1;
`else
                        state_q     <= StLost;
`endif
                    end
                end
                StLost, StFail: begin
                end
                default: begin
                    state_q     <= StRst;
                    rst_cnt_q   <= '0;
                    pll_reset_q <= 1'b1;
                    busy_q      <= 1'b1;
                end
            endcase
        end
    end

    assign pll_reset = pll_reset_q;
    assign icpsel    = prof_q.icpsel;
    assign lpfres    = prof_q.lpfres;
    assign lpfcap    = prof_q.lpfcap;
    assign busy      = busy_q;
    assign locked    = locked_q;
    assign fail      = fail_q;
    assign lock_lost = lock_lost_q;
    assign retry_cnt = retry_q;

endmodule
